lsu_ctrl: RTL

Load/store controller for the single-cycle core's LSU. It decodes each memory instruction's address into a region and drives the select of the LSU output mux (input buffer / output buffer / data memory). It sequences handshaked data-memory accesses, splitting misaligned ones into two word accesses, and stalls the core until the result is ready. It sits between the core's execute stage, the data memory, the peripheral buffers and the LSU output mux.

---
 rtl/lsu_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl - load/store controller for the single-cycle core's LSU.
//
// Decodes each memory instruction's address into a region and drives the
// LSU output mux select. Peripheral (input/output buffer) accesses finish
// in the request cycle. Data-memory accesses are sequenced over a
// req/ack handshake while the core is stalled.
//
// Data-memory handshake: o_dmem_req is held high with a stable address,
// write flag, mask and data until a cycle in which i_dmem_ack is high;
// that cycle completes the access (read data is taken from i_dmem_rdata
// in the same cycle). Ack is only looked at in DM0/DM1.
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned
// data-memory accesses into two word accesses (DM0 then DM1). Without it,
// such accesses complete immediately with o_misaligned=1 and no request.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_req, i_we         request present / store
//   i_addr, i_funct3    byte address, access size and sign
//   i_wdata             right-aligned store data
//   i_mux_rdata         word from the LSU output mux (peripheral loads)
//   i_dmem_ack/_rdata   data-memory completion and read word
//   o_stall, o_done     core freeze / access completes this cycle
//   o_rdata             extended load result
//   o_sel_output_lsu    00 ibuf, 01 obuf, 10 dmem, 11 unmapped
//   o_obuf_we           output-buffer write strobe
//   o_bmask, o_wdata    byte enables and lane-aligned write data
//   o_dmem_req/_we/_addr  data-memory request, write, word address
//   o_misaligned        misaligned fault pulse, with o_done
module lsu_ctrl (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_mux_rdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_stall,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic [1:0]  o_sel_output_lsu,
   output logic        o_obuf_we,
   output logic [3:0]  o_bmask,
   output logic [31:0] o_wdata,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic        o_misaligned
);

   localparam logic [1:0] SEL_IBUF = 2'b00;
   localparam logic [1:0] SEL_OBUF = 2'b01;
   localparam logic [1:0] SEL_DMEM = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DM0, DM1, FIN} state_t;
   state_t state, state_nxt;

   // Operation latched on entry to DM0; the core's inputs are ignored after.
   logic        op_we;
   logic [2:0]  op_f3;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic        op_split;
   logic [31:0] word0, word1;

   function automatic logic [1:0] region_of(input logic [31:0] a);
      logic [1:0] r;
      if (a[31:16] == 16'h0000)       r = SEL_DMEM;
      else if (a[31:12] == 20'h10000) r = SEL_OBUF;
      else if (a[31:12] == 20'h10010) r = SEL_IBUF;
      else                            r = SEL_NONE;
      return r;
   endfunction

   function automatic logic misaligned_of(input logic [1:0] sz, input logic [1:0] off);
      return ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
   endfunction

   function automatic logic [7:0] mask_of(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m;
   endfunction

   // Shift the two-word window right by the byte offset, then size/extend.
   function automatic logic [31:0] extract(input logic [63:0] words,
                                           input logic [1:0] off,
                                           input logic [2:0] f3);
      logic [31:0] s;
      logic [31:0] r;
      s = words[{off, 3'b000} +: 32];
      case (f3)
         3'b000:  r = {{24{s[7]}}, s[7:0]};
         3'b001:  r = {{16{s[15]}}, s[15:0]};
         3'b010:  r = s;
         3'b100:  r = {24'h0, s[7:0]};
         3'b101:  r = {16'h0, s[15:0]};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   logic [1:0]  live_region;
   logic        live_mis;
   logic [3:0]  live_mask;
   logic [31:0] live_data;
   logic [7:0]  lat_mask;
   logic [63:0] lat_data;

   always_comb begin
      live_region = region_of(i_addr);
      live_mis    = misaligned_of(i_funct3[1:0], i_addr[1:0]);
      live_mask   = 4'(mask_of(i_funct3[1:0]) << i_addr[1:0]);
      live_data   = i_wdata << {i_addr[1:0], 3'b000};
      lat_mask    = mask_of(op_f3[1:0]) << op_addr[1:0];
      lat_data    = {32'h0, op_wdata} << {op_addr[1:0], 3'b000};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         op_we    <= 1'b0;
         op_f3    <= 3'b000;
         op_addr  <= 32'h0;
         op_wdata <= 32'h0;
         op_split <= 1'b0;
         word0    <= 32'h0;
         word1    <= 32'h0;
      end else begin
         if (state == IDLE && state_nxt == DM0) begin
            op_we    <= i_we;
            op_f3    <= i_funct3;
            op_addr  <= i_addr;
            op_wdata <= i_wdata;
            op_split <= live_mis;
            word0    <= 32'h0;
            word1    <= 32'h0;
         end
         if (state == DM0 && i_dmem_ack) word0 <= i_dmem_rdata;
         if (state == DM1 && i_dmem_ack) word1 <= i_dmem_rdata;
      end
   end

   // Outputs are forced to zero while reset is asserted so a mid-access
   // reset drops the request and the stall at once, even with i_req high.
   always_comb begin
      state_nxt        = state;
      o_stall          = 1'b0;
      o_done           = 1'b0;
      o_rdata          = 32'h0;
      o_sel_output_lsu = 2'b00;
      o_obuf_we        = 1'b0;
      o_bmask          = 4'h0;
      o_wdata          = 32'h0;
      o_dmem_req       = 1'b0;
      o_dmem_we        = 1'b0;
      o_dmem_addr      = 32'h0;
      o_misaligned     = 1'b0;
      if (!i_rst) begin
         case (state)
            IDLE: begin
               if (i_req) begin
                  o_sel_output_lsu = live_region;
                  if (live_region == SEL_DMEM && !(live_mis && !SPLIT_EN)) begin
                     o_stall   = 1'b1;
                     state_nxt = DM0;
                  end else begin
                     // Peripheral, unmapped, or unsplittable misaligned access.
                     o_done       = 1'b1;
                     o_misaligned = live_mis;
                     if (!live_mis) begin
                        if (i_we) begin
                           if (live_region == SEL_OBUF) begin
                              o_obuf_we = 1'b1;
                              o_bmask   = live_mask;
                              o_wdata   = live_data;
                           end
                        end else if (live_region != SEL_NONE) begin
                           o_rdata = extract({32'h0, i_mux_rdata}, i_addr[1:0], i_funct3);
                        end
                     end
                  end
               end
            end
            DM0: begin
               o_stall          = 1'b1;
               o_sel_output_lsu = SEL_DMEM;
               o_dmem_req       = 1'b1;
               o_dmem_we        = op_we;
               o_dmem_addr      = {op_addr[31:2], 2'b00};
               if (op_we) begin
                  o_bmask = lat_mask[3:0];
                  o_wdata = lat_data[31:0];
               end
               if (i_dmem_ack) state_nxt = op_split ? DM1 : FIN;
            end
            DM1: begin
               o_stall          = 1'b1;
               o_sel_output_lsu = SEL_DMEM;
               o_dmem_req       = 1'b1;
               o_dmem_we        = op_we;
               o_dmem_addr      = {op_addr[31:2], 2'b00} + 32'd4;
               if (op_we) begin
                  o_bmask = lat_mask[7:4];
                  o_wdata = lat_data[63:32];
               end
               if (i_dmem_ack) state_nxt = FIN;
            end
            FIN: begin
               o_done           = 1'b1;
               o_sel_output_lsu = SEL_DMEM;
               if (!op_we) o_rdata = extract({word1, word0}, op_addr[1:0], op_f3);
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
